// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bus: requester side (hold/req/addr/data) and arbiter side (grant/we/waddr/wdata/stats).
interface rf_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
);
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [7:0]           conflict_cnt;

    modport master (
        output hold, req, req_addr, req_data,
        input  grant, we, waddr, wdata, conflict_cnt
    );

    modport slave (
        input  hold, req, req_addr, req_data,
        output grant, we, waddr, wdata, conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; combinational grant, write issued one cycle later.
// hold stalls all grants; ungranted requests wait. RF_ARB_FIXED_PRI0_EN gives requester 0 absolute priority.
module rf_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef RF_ARB_FIXED_PRI0_EN
    localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
    localparam logic [PW-1:0] PTR_RST = '0;
`endif

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [NREQ-1:0] grant_c;
    logic [PW-1:0]   win;
    logic            found;
    int              idx;

    // Winner search starting at ptr, wrapping modulo the round-robin ring size.
    always_comb begin
        grant_c = '0;
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        if (!rst && !bus.hold) begin
`ifdef RF_ARB_FIXED_PRI0_EN
            if (bus.req[0]) begin
                found = 1'b1;
                win   = '0;
            end
            for (int k = 0; k < NREQ - 1; k++) begin
                idx = int'(ptr_q) + k;
                if (idx > NREQ - 1) idx = idx - (NREQ - 1);
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
`endif
        end
        if (found) grant_c[win] = 1'b1;
    end

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = found;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (found) begin
            waddr_d = bus.req_addr[int'(win)*AW +: AW];
            wdata_d = bus.req_data[int'(win)*DW +: DW];
`ifdef RF_ARB_FIXED_PRI0_EN
            if (win != '0)
                ptr_d = (int'(win) == NREQ - 1) ? PW'(1) : win + PW'(1);
`else
            ptr_d = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
`endif
        end
        // Contention is counted even while stalled; saturates rather than wraps.
        if ($countones(bus.req) >= 2 && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PTR_RST;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant        = grant_c;
    assign bus.we           = we_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (default build, NREQ=4, DW=8, AW=3).
module tb_rf_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational grant settle after inputs change.
    task automatic settle();
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(i + 4);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(8'h3C + 8'h11 * i);
    endfunction

    initial begin
        rst          = 1'b1;
        bus.hold     = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;

        // Reset: grant forced to zero even with requests present.
        tick();
        bus.req = 4'b1111;
        settle();
        chk("grant_in_reset", 32'(bus.grant), 32'h0);
        tick();
        rst     = 1'b0;
        bus.req = 4'b0000;

        // Idle for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("idle_grant", 32'(bus.grant), 32'h0);
            tick();
        end
        chk("idle_we", 32'(bus.we), 32'h0);
        chk("idle_waddr", 32'(bus.waddr), 32'h0);
        chk("idle_wdata", 32'(bus.wdata), 32'h0);
        chk("idle_cnt", 32'(bus.conflict_cnt), 32'h0);

        // Single request from requester 2.
        bus.req_addr[2*AW +: AW] = 3'd5;
        bus.req_data[2*DW +: DW] = 8'hA5;
        bus.req = 4'b0100;
        settle();
        chk("single_grant", 32'(bus.grant), 32'h4);
        tick();
        bus.req = 4'b0000;
        settle();
        chk("single_we", 32'(bus.we), 32'h1);
        chk("single_waddr", 32'(bus.waddr), 32'h5);
        chk("single_wdata", 32'(bus.wdata), 32'hA5);
        chk("single_grant_drop", 32'(bus.grant), 32'h0);
        tick();
        chk("single_we_off", 32'(bus.we), 32'h0);
        chk("single_waddr_hold", 32'(bus.waddr), 32'h5);

        // Reset pulse so the pointer restarts at requester 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // All four requesting: strict rotation, one contended cycle per edge.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = addr_of(i);
            bus.req_data[i*DW +: DW] = data_of(i);
        end
        bus.req = 4'b1111;
        for (int i = 0; i <= 8; i++) begin
            settle();
            chk("rr_grant", 32'(bus.grant), 32'(1 << (i % 4)));
            chk("rr_cnt", 32'(bus.conflict_cnt), 32'(i));
            if (i > 0) begin
                chk("rr_we", 32'(bus.we), 32'h1);
                chk("rr_waddr", 32'(bus.waddr), 32'(addr_of((i - 1) % 4)));
                chk("rr_wdata", 32'(bus.wdata), 32'(data_of((i - 1) % 4)));
            end
            tick();
        end

        // Stall 3 cycles: no grants, counter still advances, pointer frozen at 1.
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_grant", 32'(bus.grant), 32'h0);
            tick();
            chk("hold_we", 32'(bus.we), 32'h0);
        end
        bus.hold = 1'b0;
        settle();
        chk("hold_cnt", 32'(bus.conflict_cnt), 32'd12);
        chk("hold_resume_grant", 32'(bus.grant), 32'h2);
        tick();

        // Saturation: two requesters for 300 cycles.
        bus.req = 4'b0011;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_cnt", 32'(bus.conflict_cnt), 32'd255);
        tick();
        chk("sat_no_wrap", 32'(bus.conflict_cnt), 32'd255);

        // Reset mid-operation: registered write still visible, grant suppressed.
        rst = 1'b1;
        settle();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_we_kept", 32'(bus.we), 32'h1);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_cnt", 32'(bus.conflict_cnt), 32'h0);
        chk("post_rst_we", 32'(bus.we), 32'h0);
        chk("post_rst_waddr", 32'(bus.waddr), 32'h0);
        chk("post_rst_grant", 32'(bus.grant), 32'h1);
        tick();
        chk("post_rst_write", 32'(bus.waddr), 32'(addr_of(0)));

        // Same address from requesters 1 and 2: serialized, last grant's data ends up written.
        bus.req_addr[1*AW +: AW] = 3'd6;
        bus.req_addr[2*AW +: AW] = 3'd6;
        bus.req_data[1*DW +: DW] = 8'h11;
        bus.req_data[2*DW +: DW] = 8'h22;
        bus.req = 4'b0110;
        settle();
        chk("same_grant1", 32'(bus.grant), 32'h2);
        tick();
        bus.req = 4'b0100;
        settle();
        chk("same_wdata1", 32'(bus.wdata), 32'h11);
        chk("same_grant2", 32'(bus.grant), 32'h4);
        tick();
        bus.req = 4'b0000;
        settle();
        chk("same_waddr2", 32'(bus.waddr), 32'h6);
        chk("same_wdata2", 32'(bus.wdata), 32'h22);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
